pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the MIPS core. It is the generalised successor to the fixed decode/execute latch. It carries an arbitrary data bundle plus a control bundle between two pipeline stages using a valid/ready handshake. It provides:
- an optional 2-entry skid buffer, which breaks the combinational ready path;
- per-entry control squashing, for branch/jump nullification;
- a whole-stage flush.

---
 rtl/pipe_pkg.sv | 35 +++
 rtl/pipe_slot.sv | 36 +++
 rtl/pipe_stage_reg.sv | 143 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline registers of the MIPS core.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stage_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    localparam int IDEX_DATA_W = 96;
    localparam int IDEX_CTRL_W = 12;

    // Control bundle bit positions that must never survive a nullified instruction.
    localparam int CTRL_REGWRITE = 0;
    localparam int CTRL_MEMWRITE = 1;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_JUMP     = 3;

    localparam logic [IDEX_CTRL_W-1:0] IDEX_SQUASH_MASK =
        (IDEX_CTRL_W'(1) << CTRL_REGWRITE) | (IDEX_CTRL_W'(1) << CTRL_MEMWRITE) |
        (IDEX_CTRL_W'(1) << CTRL_BRANCH)   | (IDEX_CTRL_W'(1) << CTRL_JUMP);

    function automatic logic [1:0] occ_of(input stage_state_t s);
        case (s)
            ONE:     return OCC_ONE;
            FULL:    return OCC_FULL;
            default: return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of a pipeline stage: data + control register with load, clear
// and squash-on-load of the control bits selected by SQUASH_MASK.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = IDEX_DATA_W,
    parameter int                CTRL_W      = IDEX_CTRL_W,
    parameter logic [CTRL_W-1:0] SQUASH_MASK = {CTRL_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic              kill,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic [DATA_W-1:0] q_data,
    output logic [CTRL_W-1:0] q_ctrl
);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values; the data register is reset too because out_data reads 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_data <= '0;
            q_ctrl <= '0;
        end else if (clear) begin
            q_data <= '0;
            q_ctrl <= '0;
        end else if (load) begin
            q_data <= d_data;
            q_ctrl <= kill ? (d_ctrl & ~SQUASH_MASK) : d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised valid/ready pipeline register with optional 2-entry skid buffer,
// per-entry control squash and whole-stage flush.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = IDEX_DATA_W,
    parameter int                CTRL_W      = IDEX_CTRL_W,
    parameter logic [CTRL_W-1:0] SQUASH_MASK = {CTRL_W{1'b1}},
    parameter int                SKID        = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              in_kill,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    stage_state_t state_q, state_d;
    logic         in_ready_q;
    logic         out_valid_q;
    logic [1:0]   occ_q;

    logic in_fire, out_fire;
    logic main_load, main_from_skid, skid_load, skid_clear;

    logic [DATA_W-1:0] main_data, skid_data;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl;

    // With the skid buffer in_ready comes straight from a flop; without it the
    // single slot can refill in the same cycle it drains.
    assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid_q || out_ready);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush) begin
            state_d    = EMPTY;
            skid_clear = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_load = 1'b1;
                        state_d   = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && (out_fire || SKID == 0)) begin
                        main_load = 1'b1;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_d   = FULL;
                    end else if (out_fire) begin
                        state_d   = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                        state_d        = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            occ_q       <= OCC_EMPTY;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != FULL);
            out_valid_q <= (state_d == ONE) || (state_d == FULL);
            occ_q       <= occ_of(state_d);
        end
    end

    // The skid entry was already squashed when it was captured, so it moves unmodified.
    pipe_slot #(
        .DATA_W     (DATA_W),
        .CTRL_W     (CTRL_W),
        .SQUASH_MASK(SQUASH_MASK)
    ) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (1'b0),
        .kill  (main_from_skid ? 1'b0 : in_kill),
        .d_data(main_from_skid ? skid_data : in_data),
        .d_ctrl(main_from_skid ? skid_ctrl : in_ctrl),
        .q_data(main_data),
        .q_ctrl(main_ctrl)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_slot #(
                .DATA_W     (DATA_W),
                .CTRL_W     (CTRL_W),
                .SQUASH_MASK(SQUASH_MASK)
            ) u_skid (
                .clk   (clk),
                .rst   (rst),
                .load  (skid_load),
                .clear (skid_clear),
                .kill  (in_kill),
                .d_data(in_data),
                .d_ctrl(in_ctrl),
                .q_data(skid_data),
                .q_ctrl(skid_ctrl)
            );
        end else begin : g_no_skid
            assign skid_data = '0;
            assign skid_ctrl = '0;
        end
    endgenerate

    assign out_valid = out_valid_q;
    assign out_data  = main_data;
    assign out_ctrl  = out_valid_q ? main_ctrl : '0;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench: a skid and a non-skid stage share one stimulus stream and are
// compared against a FIFO reference model of capacity 2 and 1 respectively.
module tb_pipe_stage_reg;

    localparam int                DATA_W = 96;
    localparam int                CTRL_W = 12;
    localparam logic [CTRL_W-1:0] MASK   = 12'h0F0;

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [CTRL_W-1:0] c;
    } entry_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_kill, flush, out_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;

    logic              in_ready1, out_valid1, in_ready0, out_valid0;
    logic [DATA_W-1:0] out_data1, out_data0;
    logic [CTRL_W-1:0] out_ctrl1, out_ctrl0;
    logic [1:0]        occ1, occ0;

    int errors = 0;
    int checks = 0;

    entry_t q1[$];
    entry_t q0[$];

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SQUASH_MASK(MASK), .SKID(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_kill(in_kill), .flush(flush),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .out_ctrl(out_ctrl1), .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SQUASH_MASK(MASK), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .in_ctrl(in_ctrl), .in_kill(in_kill), .flush(flush),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .out_ctrl(out_ctrl0), .occupancy(occ0)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Compare both DUTs against the model queues for the current inputs.
    task automatic check_outputs();
        logic [CTRL_W-1:0] c1, c0;
        c1 = (q1.size() != 0) ? q1[0].c : '0;
        c0 = (q0.size() != 0) ? q0[0].c : '0;
        check("s1_in_ready",  128'(in_ready1),  128'(q1.size() < 2));
        check("s1_out_valid", 128'(out_valid1), 128'(q1.size() != 0));
        check("s1_occupancy", 128'(occ1),       128'(q1.size()));
        check("s1_out_ctrl",  128'(out_ctrl1),  128'(c1));
        if (q1.size() != 0) check("s1_out_data", 128'(out_data1), 128'(q1[0].d));
        check("s0_in_ready",  128'(in_ready0),  128'(q0.size() == 0 || out_ready));
        check("s0_out_valid", 128'(out_valid0), 128'(q0.size() != 0));
        check("s0_occupancy", 128'(occ0),       128'(q0.size()));
        check("s0_out_ctrl",  128'(out_ctrl0),  128'(c0));
        if (q0.size() != 0) check("s0_out_data", 128'(out_data0), 128'(q0[0].d));
    endtask

    // One clock cycle with the inputs already driven; called just after a falling edge.
    task automatic step();
        entry_t e;
        bit     f1_in, f1_out, f0_in, f0_out;
        #1;
        check_outputs();
        f1_in  = in_valid  && (q1.size() < 2);
        f1_out = out_ready && (q1.size() != 0);
        f0_in  = in_valid  && (q0.size() == 0 || out_ready);
        f0_out = out_ready && (q0.size() != 0);
        e.d = in_data;
        e.c = in_kill ? (in_ctrl & ~MASK) : in_ctrl;
        @(posedge clk);
        if (flush) begin
            q1.delete();
            q0.delete();
        end else begin
            if (f1_out) void'(q1.pop_front());
            if (f1_in)  q1.push_back(e);
            if (f0_out) void'(q0.pop_front());
            if (f0_in)  q0.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        in_valid = 1'b1;
        in_data  = d;
        in_ctrl  = c;
        step();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_kill = 1'b0; flush = 1'b0; out_ready = 1'b0;
        in_data = '0; in_ctrl = '0;

        #2;
        check("rst_in_ready",  128'(in_ready1),  128'(1));
        check("rst_out_valid", 128'(out_valid1), 128'(0));
        check("rst_occupancy", 128'(occ1),       128'(0));
        check("rst_out_ctrl",  128'(out_ctrl1),  128'(0));
        check("rst_out_data",  128'(out_data1),  128'(0));
        check("rst0_out_valid", 128'(out_valid0), 128'(0));
        @(negedge clk);
        rst = 1'b0;

        // First entry appears one cycle after in_fire.
        send(96'h1234, 12'h0FF);
        in_valid = 1'b0;
        #1;
        check("first_data", 128'(out_data1), 128'(96'h1234));
        check("first_ctrl", 128'(out_ctrl1), 128'(12'h0FF));
        step();
        out_ready = 1'b1;
        step();
        step();

        // Streaming with no backpressure.
        for (int i = 1; i <= 8; i++) send(DATA_W'(i), CTRL_W'(i));
        in_valid = 1'b0;
        step();
        step();

        // Backpressure: A and B fill the skid stage, C waits upstream.
        out_ready = 1'b0;
        send(96'hA, 12'h00A);
        send(96'hB, 12'h00B);
        #1;
        check("bp_occupancy", 128'(occ1),      128'(2));
        check("bp_in_ready",  128'(in_ready1), 128'(0));
        send(96'hC, 12'h00C);
        out_ready = 1'b1;
        send(96'hC, 12'h00C);
        send(96'hC, 12'h00C);
        in_valid = 1'b0;
        step();
        step();

        // Asynchronous reset while FULL drops both slots.
        out_ready = 1'b0;
        send(96'h11, 12'h011);
        send(96'h22, 12'h022);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(out_valid1), 128'(0));
        check("midrst_occupancy", 128'(occ1),       128'(0));
        check("midrst_in_ready",  128'(in_ready1),  128'(1));
        check("midrst_out_ctrl",  128'(out_ctrl1),  128'(0));
        q1.delete();
        q0.delete();
        @(negedge clk);
        rst = 1'b0;
        step();

        // Kill squashes the masked control bits only.
        out_ready = 1'b1;
        in_kill   = 1'b1;
        send(96'hABC, 12'hFFF);
        in_kill  = 1'b0;
        in_valid = 1'b0;
        #1;
        check("kill_ctrl",      128'(out_ctrl1), 128'(12'hF0F));
        check("kill_data",      128'(out_data1), 128'(96'hABC));
        check("kill_occupancy", 128'(occ1),      128'(1));
        step();

        // Flush in FULL with an input attempt in the same cycle.
        out_ready = 1'b0;
        send(96'h31, 12'h031);
        send(96'h32, 12'h032);
        flush     = 1'b1;
        out_ready = 1'b1;
        send(96'h77, 12'h077);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_occupancy", 128'(occ1),       128'(0));
        check("flush_out_valid", 128'(out_valid1), 128'(0));
        check("flush_out_ctrl",  128'(out_ctrl1),  128'(0));
        check("flush0_out_valid", 128'(out_valid0), 128'(0));
        step();

        // Non-skid stage: in_ready follows out_ready combinationally.
        out_ready = 1'b0;
        send(96'h55, 12'h055);
        in_data = 96'h66;
        in_ctrl = 12'h066;
        #1;
        check("s0_ready_blocked", 128'(in_ready0), 128'(0));
        out_ready = 1'b1;
        #1;
        check("s0_ready_comb", 128'(in_ready0), 128'(1));
        step();
        in_valid = 1'b0;
        #1;
        check("s0_passthru_data",  128'(out_data0),  128'(96'h66));
        check("s0_passthru_valid", 128'(out_valid0), 128'(1));
        step();
        step();

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            in_valid  = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            in_kill   = $urandom_range(0, 3) == 0;
            flush     = $urandom_range(0, 15) == 0;
            in_data   = {$urandom, $urandom, $urandom};
            in_ctrl   = CTRL_W'($urandom);
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b0;
        in_kill  = 1'b0;
        out_ready = 1'b1;
        step();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
